stat_scan_out: RTL
==================

STAT_SCAN_OUT -- requirements
Module: stat_scan_out

Interface
REQ-001 Parameter: WIDTH, 16, status word width; SHALL match the status register data width.
REQ-002 Parameter: MSB_FIRST, 0, shift order; 0 SHALL shift LSB first, 1 SHALL shift MSB first.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: stat_rdata  input  WIDTH  status word from the upstream status register.
REQ-006 Port: stat_ready  input  1  high when stat_rdata is valid.
REQ-007 Port: scan_req  input  1  capture-and-shift request from the scan master, level-sampled.
REQ-008 Port: scan_en  input  1  shift enable; the bit on scan_out SHALL be consumed on a cycle where scan_en=1 and scan_valid=1.
REQ-009 Port: scan_out  output  1  current serial bit.
REQ-010 Port: scan_valid  output  1  scan_out holds a valid bit.
REQ-011 Port: scan_busy  output  1  high in every state except IDLE.
REQ-012 Port: scan_done  output  1  single-cycle pulse after the last bit is consumed.

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT, SHIFT and DONE.
REQ-014 IDLE with scan_req=1 and stat_ready=1 SHALL load stat_rdata into shadow register sh, clear bit counter cnt, and go to SHIFT.
REQ-015 IDLE with scan_req=1 and stat_ready=0 SHALL go to WAIT.
REQ-016 WAIT SHALL capture as in REQ-014 on the first cycle stat_ready=1; deasserting scan_req in WAIT SHALL abort the request and return to IDLE.
REQ-017 In SHIFT, scan_valid SHALL be 1, and scan_out SHALL be the current bit from sh, driven combinationally with zero latency.
REQ-018 A consumed bit (scan_en=1 in SHIFT) SHALL shift sh by one toward the output end, fill the vacated bit with 0, and increment cnt.
REQ-019 In SHIFT with scan_en=0, sh, cnt and scan_out SHALL hold.
REQ-020 After consuming bit number NBITS-1, the FSM SHALL go to DONE. NBITS=WIDTH, or WIDTH+1 per REQ-027.
REQ-021 DONE SHALL last exactly one cycle, assert scan_done=1 with scan_valid=0, and return to IDLE.
REQ-022 scan_req in SHIFT or DONE SHALL be ignored; it does not recapture or restart.
REQ-023 A new capture requires scan_req=1 in IDLE; a held-high scan_req SHALL re-trigger on the cycle after DONE.
REQ-024 Changes on stat_rdata after capture SHALL NOT affect the word being shifted.
REQ-025 The minimum transaction SHALL be 1 capture cycle, plus NBITS shift cycles, plus 1 DONE cycle.

Reset
REQ-026 rst=1 SHALL force IDLE, sh=0, cnt=0, scan_out=0, scan_valid=0, scan_busy=0 and scan_done=0 on the next edge, including mid-SHIFT; the partial word SHALL be discarded.

Configuration
REQ-027 With STAT_SCAN_PARITY_EN defined, one even-parity bit (XOR of the captured word) SHALL be shifted after the data bits, and NBITS SHALL be WIDTH+1.
REQ-028 Without STAT_SCAN_PARITY_EN defined, no parity logic SHALL exist, and NBITS SHALL be WIDTH.

Structure
REQ-029 Package stat_scan_pkg SHALL hold the FSM state enum, the default WIDTH constant, and the cnt width constant $clog2(WIDTH+2).
REQ-030 The parity generator SHALL be the sub-module stat_scan_parity (combinational XOR reduce), instantiated only under STAT_SCAN_PARITY_EN.
REQ-031 All remaining logic (FSM, shadow register, counter) SHALL be in stat_scan_out.

Verification
REQ-032 Basic shift:
- stimulus: stat_rdata=16'hA5C3, stat_ready=1, scan_req pulsed 1 cycle, scan_en=1 continuously, MSB_FIRST=0, no parity;
- required response: scan_out over 16 valid cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then scan_done pulses once.
REQ-033 Stall:
- stimulus: same as REQ-032 with scan_en=0 for 3 cycles after bit 4;
- required response: scan_out holds bit 4 (value 0), and the total sequence is unchanged.
REQ-034 Wait and abort:
- stimulus: scan_req=1 with stat_ready=0 for 5 cycles, then stat_ready=1 with stat_rdata=16'h8001;
- required response: stays in WAIT, then shifts 1,0,...,0,1;
- abort stimulus: scan_req dropped while in WAIT;
- abort response: returns to IDLE with no scan_done.
REQ-035 Capture isolation and ignored request:
- stimulus: stat_rdata changed to 16'hFFFF and scan_req re-pulsed mid-SHIFT;
- required response: the original word completes, and no restart occurs.
REQ-036 Reset mid-shift:
- stimulus: rst=1 at bit 7;
- required response: next cycle scan_valid=0, scan_busy=0, scan_out=0, and no scan_done.
REQ-037 Parity (STAT_SCAN_PARITY_EN defined):
- stimulus: stat_rdata=16'h0001, then 16'hA5C3;
- required response: bit 16 = 1 for 16'h0001, bit 16 = 0 for 16'hA5C3, with scan_done after 17 bits.

Source files
------------

// File: rtl/stat_scan_pkg.sv
// Shared types and constants for the status scan-out unit.
// Holds the FSM state enum, default word width and counter width.
package stat_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam int STAT_W = 16;
  localparam int CNT_W  = $clog2(STAT_W + 2);

endpackage

// File: rtl/stat_scan_parity.sv
// Even-parity generator for the captured status word.
// Used only when STAT_SCAN_PARITY_EN is defined.
module stat_scan_parity #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_par
);

  assign o_par = ^i_data;

endmodule

// File: rtl/stat_scan_out.sv
// Captures a status word and shifts it out serially under scan_en.
// Define STAT_SCAN_PARITY_EN to append an even-parity bit.
module stat_scan_out
  import stat_scan_pkg::*;
#(
  parameter int WIDTH     = STAT_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] stat_rdata,
  input  logic             stat_ready,
  input  logic             scan_req,
  input  logic             scan_en,
  output logic             scan_out,
  output logic             scan_valid,
  output logic             scan_busy,
  output logic             scan_done
);

`ifdef STAT_SCAN_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  state_t           r_state;
  state_t           w_next;
  logic [NBITS-1:0] r_sh;
  logic [NBITS-1:0] w_cap;
  logic [CW-1:0]    r_cnt;
  logic             w_load;
  logic             w_shift;
  logic             w_last;

`ifdef STAT_SCAN_PARITY_EN
  logic w_par;

  stat_scan_parity #(
    .WIDTH (WIDTH)
  ) u_par (
    .i_data (stat_rdata),
    .o_par  (w_par)
  );

  // Parity sits behind the data in shift order.
  assign w_cap = MSB_FIRST ? {stat_rdata, w_par}
                           : {w_par, stat_rdata};
`else
  assign w_cap = stat_rdata;
`endif

  assign w_last = (r_cnt == CW'(NBITS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (scan_req) begin
          if (stat_ready) begin
            w_load = 1'b1;
            w_next = S_SHIFT;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!scan_req) begin
          w_next = S_IDLE;
        end else if (stat_ready) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (scan_en) begin
          w_shift = 1'b1;
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_sh  <= w_cap;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_sh  <= MSB_FIRST ? {r_sh[NBITS-2:0], 1'b0}
                         : {1'b0, r_sh[NBITS-1:1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign scan_valid = (r_state == S_SHIFT);
  assign scan_busy  = (r_state != S_IDLE);
  assign scan_done  = (r_state == S_DONE);
  assign scan_out   = scan_valid &
                      (MSB_FIRST ? r_sh[NBITS-1] : r_sh[0]);

endmodule
